// File: rtl/wb_slave_pkg.sv
// Shared types and constants for the Wishbone SRAM responder.
package wb_slave_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a mask over bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Default-width response entry; the top supplies a DAT_WIDTH-sized twin to wb_resp_pipe
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } resp_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle; dat_i/dat_o are named from the responder's side.
interface wb_if #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32
);
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [DAT_WIDTH/8-1:0] sel;
    logic [ADR_WIDTH-1:0]   adr;
    logic [DAT_WIDTH-1:0]   dat_i;
    logic                   stall;
    logic                   ack;
    logic [DAT_WIDTH-1:0]   dat_o;

    modport master (output cyc, stb, we, sel, adr, dat_i, input stall, ack, dat_o);
    modport slave  (input cyc, stb, we, sel, adr, dat_i, output stall, ack, dat_o);
endinterface

// File: rtl/wb_resp_pipe.sv
// LATENCY-deep response shift register; flush_i drops every in-flight valid bit.
module wb_resp_pipe
    import wb_slave_pkg::*;
#(
    parameter int  LATENCY  = 1,
    parameter type resp_t_p = resp_t
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush_i,
    input  resp_t_p in_i,
    output resp_t_p out_o
);

    resp_t_p stage_q [LATENCY];

    always_ff @(posedge clk) begin
        stage_q[0].data <= in_i.data;
        for (int i = 1; i < LATENCY; i++) begin
            stage_q[i].data <= stage_q[i-1].data;
        end
        if (rst || flush_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end else begin
            stage_q[0].valid <= in_i.valid;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i].valid <= stage_q[i-1].valid;
            end
        end
    end

    assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/wb_sram_slave.sv
// Pipelined Wishbone B4 SRAM responder with configurable ack latency and outstanding limit.
// Optional build macro WB_SLAVE_STALL_INJECT_EN adds LFSR-driven random stalls.
module wb_sram_slave
    import wb_slave_pkg::*;
#(
    parameter int ADR_WIDTH       = 32,
    parameter int DAT_WIDTH       = 32,
    parameter int DEPTH           = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic clk,
    input logic rst,
    wb_if.slave bus
);

    localparam int SEL_W = DAT_WIDTH / 8;
    localparam int OFF_W = $clog2(SEL_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef struct packed {
        logic                 valid;
        logic [DAT_WIDTH-1:0] data;
    } resp_w_t;

    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]     idx;
    logic                 accept;
    logic                 ack_int;
    logic                 stall_int;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    resp_w_t              req_resp;
    resp_w_t              pipe_out;
    logic                 unused_adr;

    // Upper address bits alias onto the same words
    assign idx        = bus.adr[OFF_W +: IDX_W];
    assign unused_adr = ^bus.adr;

`ifdef WB_SLAVE_STALL_INJECT_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign stall_int = bus.cyc && ((cnt_q == CNT_MAX) || (lfsr_q[1:0] == 2'b00));
`else
    assign stall_int = bus.cyc && (cnt_q == CNT_MAX);
`endif

    assign accept = bus.cyc && bus.stb && !stall_int;

    always_ff @(posedge clk) begin
        if (accept && bus.we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (bus.sel[b]) mem[idx][8*b +: 8] <= bus.dat_i[8*b +: 8];
            end
        end
    end

    // Read sees the pre-write word because the write only lands at the edge
    always_comb begin
        req_resp.valid = accept;
        req_resp.data  = bus.we ? '0 : mem[idx];
    end

    wb_resp_pipe #(
        .LATENCY  (LATENCY),
        .resp_t_p (resp_w_t)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush_i (!bus.cyc),
        .in_i    (req_resp),
        .out_o   (pipe_out)
    );

    assign ack_int = pipe_out.valid && bus.cyc;

    always_comb begin
        cnt_d = cnt_q;
        if (!bus.cyc)                cnt_d = '0;
        else if (accept && !ack_int) cnt_d = cnt_q + CNT_W'(1);
        else if (!accept && ack_int) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.stall = stall_int;
    assign bus.ack   = ack_int;
    assign bus.dat_o = ack_int ? pipe_out.data : '0;

endmodule
